// File: rtl/seg7_pkg.sv
// Shared glyph table and width helper for the multiplexed 7-segment scanner.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied later.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Counter width for a range of 'value' states, never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/display7seg_scan_if.sv
// Display-side bundle: digit data and display controls in, panel pins out.
interface display7seg_scan_if #(
    parameter int N_DIGITS = 4
) ();

    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blink_mask;
    logic [3:0]            brightness;
    logic                  lz_blank;
    logic                  hex_mode;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_tick;

    modport master (
        output digits_in, dp_in, blink_mask, brightness, lz_blank, hex_mode,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, blink_mask, brightness, lz_blank, hex_mode,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-high segment pattern; 10..15 show A-F only in hex mode.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_hex_mode,
    output logic [6:0] o_seg
);

    // Glyph lookup.
    always_comb begin
        o_seg = SEG_OFF;
        case (i_value)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            4'd10:   o_seg = i_hex_mode ? SEG_A : SEG_OFF;
            4'd11:   o_seg = i_hex_mode ? SEG_B : SEG_OFF;
            4'd12:   o_seg = i_hex_mode ? SEG_C : SEG_OFF;
            4'd13:   o_seg = i_hex_mode ? SEG_D : SEG_OFF;
            4'd14:   o_seg = i_hex_mode ? SEG_E : SEG_OFF;
            4'd15:   o_seg = i_hex_mode ? SEG_F : SEG_OFF;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display7seg_scan.sv
// N-digit multiplexed 7-segment driver: slot/frame scanning, frame-synchronous
// input shadowing, anti-ghosting guard band, PWM brightness, blink and blanking.
module display7seg_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 16,
    parameter int BLINK_FRAMES   = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    display7seg_scan_if.slave  bus
);

    localparam int SLOT_W  = clog2(SCAN_DIV);
    localparam int SEL_W   = clog2(N_DIGITS);
    localparam int BLINK_W = clog2(BLINK_FRAMES);

    localparam logic [SLOT_W-1:0]   SLOT_LAST   = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]   GUARD_END   = SLOT_W'(GUARD);
    localparam logic [SEL_W-1:0]    SEL_LAST    = SEL_W'(N_DIGITS - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]          SEG_POL     = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] AN_POL      = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic [3:0]          r_pwm_cnt;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;
    logic [3:0]          r_digit [N_DIGITS];
    logic [N_DIGITS-1:0] r_dp_mask;
    logic [N_DIGITS-1:0] r_blink_mask;
    logic                r_lz_blank;
    logic                r_hex_mode;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [N_DIGITS-1:0] r_an;
    logic                r_frame_tick;

    logic                w_slot_end;
    logic                w_frame_end;
    logic [3:0]          w_value;
    logic [6:0]          w_glyph;
    logic [N_DIGITS-1:0] w_zero_from;
    logic [N_DIGITS-1:0] w_an_onehot;
    logic                w_lz_hide;
    logic                w_blink_hide;
    logic                w_lit;

    assign w_slot_end   = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end  = w_slot_end && (r_sel == SEL_LAST);
    assign w_value      = r_digit[r_sel];
    assign w_lz_hide    = r_lz_blank && (r_sel != '0) && w_zero_from[r_sel];
    assign w_blink_hide = r_blink_mask[r_sel] && !r_blink_phase;
    assign w_lit        = (r_slot_cnt >= GUARD_END) && (r_pwm_cnt <= bus.brightness)
                          && !w_lz_hide && !w_blink_hide;

    seg7_decode u_decode (
        .i_value    (w_value),
        .i_hex_mode (r_hex_mode),
        .o_seg      (w_glyph)
    );

    // Zero-run from the top digit downward, plus the one-hot anode for sel.
    always_comb begin : blank_and_select
        logic w_run_zero;
        w_run_zero  = 1'b1;
        w_zero_from = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_run_zero     = w_run_zero & (r_digit[i] == 4'd0);
            w_zero_from[i] = w_run_zero;
        end
        w_an_onehot        = '0;
        w_an_onehot[r_sel] = 1'b1;
    end

    // Slot, digit-select and PWM counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt <= '0;
            r_sel      <= '0;
            r_pwm_cnt  <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                if (r_sel == SEL_LAST) begin
                    r_sel <= '0;
                end else begin
                    r_sel <= r_sel + SEL_W'(1);
                end
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Frame boundary: shadow the inputs so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_digit[i] <= 4'd0;
            end
            r_dp_mask     <= '0;
            r_blink_mask  <= '0;
            r_lz_blank    <= 1'b0;
            r_hex_mode    <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_digit[i] <= bus.digits_in[4*i +: 4];
            end
            r_dp_mask    <= bus.dp_in;
            r_blink_mask <= bus.blink_mask;
            r_lz_blank   <= bus.lz_blank;
            r_hex_mode   <= bus.hex_mode;
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end else begin
            r_blink_cnt <= r_blink_cnt;
        end
    end

    // Pin registers; an unlit anode also forces segments and dp off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an         <= AN_POL;
            r_seg        <= SEG_POL;
            r_dp         <= SEG_ACTIVE_LOW;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_lit ? (w_an_onehot ^ AN_POL) : AN_POL;
            r_seg        <= w_lit ? (w_glyph ^ SEG_POL) : SEG_POL;
            r_dp         <= (w_lit && r_dp_mask[r_sel]) ^ SEG_ACTIVE_LOW;
            r_frame_tick <= w_frame_end;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: doc/display7seg_scan.md
Name: display7seg_scan

Overview:
- Parametrised N-digit multiplexed 7-segment driver.
- Successor to the fixed 4-digit scanner, with:
  - a clock-enable scan tick instead of a derived clock
  - frame-synchronous input shadowing
  - an anti-ghosting guard band
  - 16-level brightness PWM
  - per-digit blink and decimal point
  - leading-zero blanking
  - hex/BCD decode mode
- Sits between the occupancy/counter logic and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>= GUARD+2).
- GUARD, 16, cycles at slot start with all anodes inactive.
- BLINK_FRAMES, 250, frames per blink half-period (>= 1).
- SEG_ACTIVE_LOW, 1, 1: seg/dp driven 0 = lit.
- AN_ACTIVE_LOW, 1, 1: an driven 0 = digit enabled.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active low
- digits_in  in  4*N_DIGITS  digit values, digit 0 in [3:0] (least significant)
- dp_in  in  N_DIGITS  decimal point request per digit
- blink_mask  in  N_DIGITS  1 = digit blinks
- brightness  in  4  duty level 0..15
- lz_blank  in  1  enable leading-zero blanking
- hex_mode  in  1  1: values 10..15 shown as A-F; 0: shown blank
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
- an  out  N_DIGITS  digit enables, polarity per AN_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync-released use):
  - slot_cnt=0, sel=0, pwm_cnt=0, blink_cnt=0, blink_phase=1 (visible)
  - shadow registers (digits, dp, blink_mask, lz_blank, hex_mode) = 0
  - an = all inactive, seg = all off, dp = off, frame_tick = 0
- slot_cnt: counts 0..SCAN_DIV-1 every clk, then wraps to 0.
- Slot end (slot_cnt == SCAN_DIV-1): sel advances. When sel == N_DIGITS-1 it wraps to 0 and that cycle is a frame boundary.
- Frame boundary actions (same edge):
  - shadow registers load from the inputs
  - frame_tick=1 on the next cycle
  - blink_cnt increments; at BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase
- Inputs are sampled only at frame boundaries, so there is no mid-frame tearing. Display latency is at most one frame plus 1 cycle.
- brightness is not shadowed; it takes effect within 16 cycles.
- pwm_cnt: 4-bit free-running counter, +1 every clk.
- Digit s = sel is lit on cycle t+1 iff, on cycle t, all of the following hold:
  - slot_cnt >= GUARD
  - pwm_cnt <= brightness (15 = 100%, 0 = 1/16)
  - digit not blanked
- Blanked digit = any of:
  - lz_blank=1, s != 0, and all shadow digits s..N_DIGITS-1 equal 0
  - blink_mask[s]=1 and blink_phase=0
  - hex_mode=0 and value >= 10: segments off, but the anode is still eligible so dp can show
- Decode (active-high before polarity): standard 0-9; A,b,C,d,E,F for 10..15.
- When the anode is inactive, seg and dp are also driven off.
- seg, dp, an and frame_tick are all registered. At most one anode is active in any cycle.
- Polarity is applied at the output register by XOR with the parameter.
- Digit 0 is never leading-zero blanked, so the value 0 displays as "0".

Decomposition:
- Package seg7_pkg:
  - SEG_* 7-bit glyph constants for 0-9 and A-F, plus SEG_OFF
  - function clog2 for the sel and counter widths
- Sub-module seg7_decode (combinational): value[3:0] + hex_mode -> seg[6:0] active-high.
- The top holds all counters, shadowing and the output registers.

Test Plan (N_DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2, both polarities active-low):
- Reset check: hold reset_n=0, then release.
  - During reset: an=4'b1111, seg=7'b1111111, dp=1.
  - After release: first an=4'b1110 appears at cycle GUARD+1.
  - First frame_tick pulses at cycle 32 after release.
- Scan and anti-ghosting: digits_in=16'h1234, brightness=15.
  - Each slot shows an 1110/1101/1011/0111 with seg 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
  - Exactly 2 all-ones an cycles at each slot start.
- Frame shadowing: change digits_in to 16'h5678 mid-slot 1. Displayed digits stay 1234 until the next frame boundary, then show 5678 with no mixed frame.
- Leading-zero blanking: digits_in=16'h0050, lz_blank=1.
  - Digits 3 and 2 anodes never active; digit 1 shows 5; digit 0 shows 0.
  - With digits_in=16'h0000, only digit 0 is lit, showing 0.
- Blink, hex and dp: blink_mask=4'b0001, hex_mode=1, digits_in=16'h00AF, dp_in=4'b0010.
  - Digit 0 shows F for 2 frames, then is dark for 2 frames.
  - Digit 1 shows A with dp=0.
  - With hex_mode=0, digit 1 has seg off but dp still lit.
- Brightness and mid-operation reset:
  - brightness=3: within lit region, anode active exactly 4 of every 16 cycles.
  - Assert reset_n mid-slot: outputs go inactive immediately (asynchronous). After release, scanning restarts at sel=0.
